// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack and sticky stack error flags.
// Latency: the next PC is registered and appears one cycle after the select/enable inputs are sampled.
// Backpressure: PC_enable=0 stalls PC, PC_temp and the stack; Debug_load overrides the stall.
module pc_sequencer #(
    parameter int                 ADDR_W     = 32,
    parameter int                 RAS_DEPTH  = 4,
    parameter int                 JUMP_W     = 7,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic                           Clock,
    input  logic                           Reset_n,
    input  logic                           PC_enable,
    input  logic [2:0]                     PC_select,
    input  logic [ADDR_W-1:0]              BranchOff,
    input  logic [ADDR_W-1:0]              RA,
    input  logic                           Debug_load,
    input  logic [JUMP_W-1:0]              JumpTo,
    input  logic                           Err_clear,
    output logic [ADDR_W-1:0]              PC,
    output logic [ADDR_W-1:0]              PC_temp,
    output logic [$clog2(RAS_DEPTH):0]     RAS_count,
    output logic                           RAS_overflow,
    output logic                           RAS_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_temp_q, pc_temp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // ptr_q points one past the top entry; the buffer is circular, so a push
    // into a full stack lands on the oldest entry and discards it.
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ovf_set, unf_set;
    logic              push_en;
    logic [ADDR_W-1:0] pc_inc;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign top_idx = ptr_q - PTR_W'(1);

    // Next-state selection: debug load first, then the enabled PC_select modes.
    always_comb begin
        pc_d      = pc_q;
        pc_temp_d = pc_temp_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        push_en   = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (Debug_load) begin
            pc_d      = ADDR_W'(JumpTo);
            pc_temp_d = pc_q;
            cnt_d     = '0;
        end else if (PC_enable) begin
            case (PC_select)
                3'd0: begin
                    pc_d      = RA;
                    pc_temp_d = pc_q;
                end
                3'd1: begin
                    pc_d      = pc_inc;
                    pc_temp_d = pc_q;
                end
                3'd2: begin
                    pc_d      = pc_q + BranchOff;
                    pc_temp_d = pc_q;
                end
                3'd3: begin
                    pc_d      = BranchOff;
                    pc_temp_d = pc_q;
                end
                3'd4: begin
                    pc_d      = BranchOff;
                    pc_temp_d = pc_q;
                    push_en   = 1'b1;
                    ptr_d     = ptr_q + PTR_W'(1);
                    if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ovf_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                3'd5: begin
                    pc_temp_d = pc_q;
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[top_idx];
                        ptr_d = top_idx;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d    = RA;
                        unf_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // A set event in the same cycle as Err_clear keeps the flag raised.
        ovf_d = ovf_set | (ovf_q & ~Err_clear);
        unf_d = unf_set | (unf_q & ~Err_clear);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q      <= RESET_ADDR;
            pc_temp_q <= RESET_ADDR;
            cnt_q     <= '0;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pc_temp_q <= pc_temp_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Stack storage; entries above the count are never read, so no reset.
    always_ff @(posedge Clock) begin
        if (push_en) begin
            ras_q[ptr_q] <= pc_inc;
        end
    end

    assign PC            = pc_q;
    assign PC_temp       = pc_temp_q;
    assign RAS_count     = cnt_q;
    assign RAS_overflow  = ovf_q;
    assign RAS_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [31:0] bo = '0;
    logic [31:0] ra = '0;
    logic        dbg = 1'b0;
    logic [6:0]  jt = '0;
    logic        clr = 1'b0;
    logic [31:0] pc_o, pct_o;
    logic [2:0]  cnt_o;
    logic        ovf_o, unf_o;

    // narrow instance for the wrap-around case
    logic        en8 = 1'b0;
    logic [2:0]  sel8 = 3'd0;
    logic [7:0]  bo8 = '0;
    logic        dbg8 = 1'b0;
    logic [6:0]  jt8 = '0;
    logic [7:0]  pc8, pct8;
    logic [2:0]  cnt8;
    logic        ovf8, unf8;
    bit          d8_done = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pct;
        int          cnt;
        bit          ovf;
        bit          unf;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_pc, m_pct;
    logic [31:0] m_stk[$];
    bit          m_ovf, m_unf;

    always #5 Clock = ~Clock;

    pc_sequencer #(.ADDR_W(32), .RAS_DEPTH(DEPTH), .JUMP_W(7)) dut (
        .Clock(Clock), .Reset_n(rst_n), .PC_enable(en), .PC_select(sel),
        .BranchOff(bo), .RA(ra), .Debug_load(dbg), .JumpTo(jt), .Err_clear(clr),
        .PC(pc_o), .PC_temp(pct_o), .RAS_count(cnt_o),
        .RAS_overflow(ovf_o), .RAS_underflow(unf_o)
    );

    pc_sequencer #(.ADDR_W(8), .RAS_DEPTH(DEPTH), .JUMP_W(7)) dut8 (
        .Clock(Clock), .Reset_n(rst_n), .PC_enable(en8), .PC_select(sel8),
        .BranchOff(bo8), .RA(8'h00), .Debug_load(dbg8), .JumpTo(jt8), .Err_clear(1'b0),
        .PC(pc8), .PC_temp(pct8), .RAS_count(cnt8),
        .RAS_overflow(ovf8), .RAS_underflow(unf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = '0; m_pct = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    endtask

    // One clock edge of the architectural behaviour, using a bounded LIFO queue.
    task automatic m_step();
        bit os = 0, us = 0;
        logic [31:0] old = m_pc;
        if (dbg) begin
            m_pc = {25'd0, jt};
            m_pct = old;
            m_stk.delete();
        end else if (en && sel <= 3'd5) begin
            m_pct = old;
            case (sel)
                3'd0: m_pc = ra;
                3'd1: m_pc = old + 1;
                3'd2: m_pc = old + bo;
                3'd3: m_pc = bo;
                3'd4: begin
                    m_pc = bo;
                    m_stk.push_back(old + 1);
                    if (m_stk.size() > DEPTH) begin
                        void'(m_stk.pop_front());
                        os = 1;
                    end
                end
                default: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_pc = ra;
                        us = 1;
                    end
                end
            endcase
        end
        m_ovf = os | (m_ovf & !clr);
        m_unf = us | (m_unf & !clr);
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc = m_pc; e.pct = m_pct; e.cnt = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    // Drive at a falling edge, predict, then move to the next falling edge.
    task automatic apply(input bit e_, input logic [2:0] s_, input logic [31:0] b_,
                         input logic [31:0] r_, input bit d_, input logic [6:0] j_, input bit c_);
        en = e_; sel = s_; bo = b_; ra = r_; dbg = d_; jt = j_; clr = c_;
        m_step();
        push_exp();
        @(negedge Clock);
    endtask

    // Reset pulse between edges while a CALL is presented; the following edge acts normally.
    task automatic reset_pulse_call(input logic [31:0] b_);
        en = 1; sel = 3'd4; bo = b_; ra = '0; dbg = 0; jt = '0; clr = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc_o, 32'd0);
        chk("async_rst_pct", pct_o, 32'd0);
        chk("async_rst_cnt", {29'd0, cnt_o}, 32'd0);
        chk("async_rst_ovf", {31'd0, ovf_o}, 32'd0);
        chk("async_rst_unf", {31'd0, unf_o}, 32'd0);
        #1 rst_n = 1'b1;
        m_reset();
        m_step();
        push_exp();
        @(negedge Clock);
    endtask

    // Monitor: every rising edge produces one architectural state to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc_o, e.pc);
                chk("pc_temp", pct_o, e.pct);
                chk("ras_count", {29'd0, cnt_o}, e.cnt);
                chk("ras_overflow", {31'd0, ovf_o}, {31'd0, e.ovf});
                chk("ras_underflow", {31'd0, unf_o}, {31'd0, e.unf});
            end
        end
    end

    // Narrow instance: debug load to 7F, jump to FF, then increment wraps to 00.
    initial begin
        @(posedge rst_n);
        @(negedge Clock);
        en8 = 1; dbg8 = 1; jt8 = 7'h7F;
        @(negedge Clock);
        chk("w8_dbg_pc", {24'd0, pc8}, 32'h7F);
        dbg8 = 0; sel8 = 3'd3; bo8 = 8'hFF;
        @(negedge Clock);
        chk("w8_abs_pc", {24'd0, pc8}, 32'hFF);
        sel8 = 3'd1;
        @(negedge Clock);
        chk("w8_wrap_pc", {24'd0, pc8}, 32'h00);
        chk("w8_wrap_pct", {24'd0, pct8}, 32'hFF);
        en8 = 0;
        d8_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int calls[5] = '{20, 40, 60, 80, 100};
        m_reset();
        repeat (2) @(negedge Clock);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pct", pct_o, 32'd0);
        chk("rst_cnt", {29'd0, cnt_o}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
        chk("rst_unf", {31'd0, unf_o}, 32'd0);
        rst_n = 1'b1;

        // sequential increments
        repeat (4) apply(1, 3'd1, '0, '0, 0, '0, 0);
        // relative branch backwards from 10
        apply(1, 3'd3, 32'd10, '0, 0, '0, 0);
        apply(1, 3'd2, -32'sd3, '0, 0, '0, 0);
        // stack: back to 0, five calls (last overflows), five returns (last underflows)
        apply(0, 3'd0, '0, '0, 1, 7'd0, 0);
        foreach (calls[i]) apply(1, 3'd4, calls[i], '0, 0, '0, 0);
        repeat (4) apply(1, 3'd5, '0, 32'd7, 0, '0, 0);
        apply(1, 3'd5, '0, 32'd99, 0, '0, 0);
        // stall with CALL selected
        repeat (3) apply(0, 3'd4, 32'd500, '0, 0, '0, 0);
        // debug load beats an enabled CALL
        apply(1, 3'd4, 32'd600, '0, 1, 7'h55, 0);
        // fill, then overflow in the same cycle as a clear; then clear both flags
        repeat (4) apply(1, 3'd4, 32'd30, '0, 0, '0, 0);
        apply(1, 3'd4, 32'd40, '0, 0, '0, 1);
        apply(1, 3'd1, '0, '0, 0, '0, 1);
        // asynchronous reset pulse during a CALL
        reset_pulse_call(32'd44);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse_call($urandom);
            end else begin
                apply($urandom_range(0, 9) != 0,
                      3'($urandom_range(0, 7)),
                      ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom,
                      $urandom,
                      $urandom_range(0, 19) == 0,
                      7'($urandom),
                      $urandom_range(0, 9) == 0);
            end
        end

        en = 0; dbg = 0; clr = 0;
        repeat (3) @(negedge Clock);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        for (int k = 0; k < 20 && !d8_done; k++) @(negedge Clock);
        chk("w8_done", {31'd0, d8_done}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the PC, offset and return-address width in bits.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, giving the number of return-address-stack entries; legal values are powers of two from 2 to 16.
REQ-003 The block SHALL have parameter JUMP_W, default 7, giving the debug jump-target width in bits.
REQ-004 The block SHALL have parameter RESET_ADDR, default 0, giving the PC value loaded on reset.

Ports:
REQ-005 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port PC_enable, input, 1 bit: advance PC this cycle; 0 = stall.
REQ-008 The block SHALL have port PC_select, input, 3 bits: next-PC mode (REQ-020).
REQ-009 The block SHALL have port BranchOff, input, ADDR_W bits: relative offset (two's complement) or absolute target.
REQ-010 The block SHALL have port RA, input, ADDR_W bits: register-file return address.
REQ-011 The block SHALL have port Debug_load, input, 1 bit: load PC from JumpTo.
REQ-012 The block SHALL have port JumpTo, input, JUMP_W bits: debug target, zero-extended to ADDR_W.
REQ-013 The block SHALL have port Err_clear, input, 1 bit: clear the sticky error flags.
REQ-014 The block SHALL have port PC, output, ADDR_W bits: current instruction address (registered).
REQ-015 The block SHALL have port PC_temp, output, ADDR_W bits: PC value before the last PC update (registered).
REQ-016 The block SHALL have port RAS_count, output, clog2(RAS_DEPTH)+1 bits: number of valid stack entries.
REQ-017 The block SHALL have port RAS_overflow, output, 1 bit: sticky flag, set when a call occurs with the stack full.
REQ-018 The block SHALL have port RAS_underflow, output, 1 bit: sticky flag, set when a return occurs with the stack empty.

Function
REQ-019 All PC arithmetic SHALL be modulo 2^ADDR_W; carry out SHALL be discarded (wrap-around, no flag).
REQ-020 When PC_enable=1 and Debug_load=0, the next PC SHALL be selected by PC_select as follows:
- 0: RA
- 1: PC+1
- 2: PC+BranchOff
- 3: BranchOff
- 4 (CALL): BranchOff, and PC+1 is pushed onto the stack
- 5 (RETURN): the popped stack top
- 6 and 7: PC held, with no state change
REQ-021 An update SHALL occur on the rising edge; the new PC is visible one cycle after the select/enable inputs are sampled.
REQ-022 On every edge where PC changes due to REQ-020 or REQ-024, PC_temp SHALL load the old PC; otherwise PC_temp SHALL hold.
REQ-023 PC_enable=0 SHALL hold PC, PC_temp, the stack and RAS_count, regardless of PC_select.
REQ-024 Debug_load=1 SHALL have priority over PC_enable: PC <= zero-extended JumpTo, RAS_count <= 0, and the error flags are unaffected.
REQ-025 The stack SHALL be LIFO; CALL with count<RAS_DEPTH SHALL write the top entry and increment the count.
REQ-026 CALL with count=RAS_DEPTH SHALL discard the oldest entry, push the new one, hold the count at RAS_DEPTH, and set RAS_overflow.
REQ-027 RETURN with count>0 SHALL load PC with the top entry and decrement the count.
REQ-028 RETURN with count=0 SHALL load PC from RA, leave the count at 0, and set RAS_underflow.
REQ-029 Err_clear=1 SHALL clear both flags; a same-cycle set event SHALL win over the clear.
REQ-030 Stack contents beyond RAS_count SHALL be don't-care and never observable on PC.

Reset
REQ-031 Reset_n=0 SHALL immediately, without a clock, force the following values:
- PC = RESET_ADDR
- PC_temp = RESET_ADDR
- RAS_count = 0
- RAS_overflow = 0
- RAS_underflow = 0
REQ-032 Reset asserted mid-CALL or mid-RETURN SHALL abandon that operation; the first edge after release SHALL act normally on the sampled inputs.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset release, PC_select=1, PC_enable=1 for 4 cycles -> PC 0,1,2,3,4; PC_temp trails by one.
- PC=10, select=2, BranchOff=-3 -> PC=7, PC_temp=10. Then with ADDR_W=8, PC=8'hFF, select=1 -> PC=8'h00.
- RAS_DEPTH=4, five CALLs from PC=0,20,40,60,80 with BranchOff=20,40,60,80,100 -> RAS_count=4, RAS_overflow=1. Then four RETURNs -> PC=81,61,41,21. A fifth RETURN with RA=99 -> PC=99, RAS_underflow=1.
- PC_enable=0 with select=4 for 3 cycles -> PC, PC_temp and RAS_count unchanged.
- Debug_load=1, JumpTo=7'h55, PC_enable=1, select=4 -> PC=32'h55, RAS_count=0, no push. Err_clear with a simultaneous overflow -> flag stays 1.
- Reset_n pulsed low between edges during a CALL -> PC=RESET_ADDR and count=0 asynchronously.
